// File: rtl/wb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wb_pipe
// Purpose  : Registered write-back stage. Holds the MEM/WB pipeline entry
//            with valid/stall/flush control, extracts load data (byte, half,
//            word, signed or unsigned), flags misaligned loads, suppresses
//            writes to x0 and counts retired (captured) instructions.
// Ports    :
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   valid_i        MEM stage presents a valid instruction
//   stall_i        hold the pipeline register contents
//   flush_i        replace the incoming instruction with a bubble
//   instr_i        instruction word (opcode and funct3 are kept)
//   data_mem_i     raw aligned word read from data memory
//   data_i         ALU result
//   pc_next_i      PC+4 link value for JAL/JALR
//   mem_addr_i     low two bits of the load address
//   wbaddr_i       destination register
//   wbdata_o       write-back data
//   wbaddr_o       write-back register address
//   wb_en          register-file write enable
//   valid_o        registered entry is valid
//   misaligned_o   registered entry is a misaligned load
//   instret_o      retired instruction count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module wb_pipe #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [31:0]        instr_i,
  input  logic [XLEN-1:0]    data_mem_i,
  input  logic [XLEN-1:0]    data_i,
  input  logic [XLEN-1:0]    pc_next_i,
  input  logic [1:0]         mem_addr_i,
  input  logic [RADDR_W-1:0] wbaddr_i,
  output logic [XLEN-1:0]    wbdata_o,
  output logic [RADDR_W-1:0] wbaddr_o,
  output logic               wb_en,
  output logic               valid_o,
  output logic               misaligned_o,
  output logic [CNT_W-1:0]   instret_o
);

  // Opcodes that produce a register result
  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_IMM   = 7'b0010011;
  localparam logic [6:0] c_OP_REG   = 7'b0110011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

  // Load funct3 encodings
  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Pipeline register. Only the opcode and funct3 fields of the instruction
  // are consumed downstream, so only those are stored.
  // --------------------------------------------------------------------------
  logic               r_valid;
  logic [6:0]         r_opcode;
  logic [2:0]         r_funct3;
  logic [XLEN-1:0]    r_data_mem;
  logic [XLEN-1:0]    r_data;
  logic [XLEN-1:0]    r_pc_next;
  logic [1:0]         r_mem_addr;
  logic [RADDR_W-1:0] r_wbaddr;
  logic [CNT_W-1:0]   r_instret;

  // Remaining instruction bits are decoded elsewhere in the pipeline.
  logic w_unused_instr;
  assign w_unused_instr = ^{instr_i[31:15], instr_i[11:7]};

  // A capture happens only when the entry is accepted, so a stalled entry
  // is counted once no matter how long it is held.
  logic w_capture;
  assign w_capture = ~flush_i & ~stall_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_opcode   <= 7'd0;
      r_funct3   <= 3'd0;
      r_data_mem <= '0;
      r_data     <= '0;
      r_pc_next  <= '0;
      r_mem_addr <= 2'd0;
      r_wbaddr   <= '0;
    end else if (flush_i) begin
      // Flush beats stall: the entry becomes a bubble, payload is left as is.
      r_valid <= 1'b0;
    end else if (!stall_i) begin
      r_valid    <= valid_i;
      r_opcode   <= instr_i[6:0];
      r_funct3   <= instr_i[14:12];
      r_data_mem <= data_mem_i;
      r_data     <= data_i;
      r_pc_next  <= pc_next_i;
      r_mem_addr <= mem_addr_i;
      r_wbaddr   <= wbaddr_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret <= '0;
    end else if (w_capture && valid_i) begin
      r_instret <= r_instret + c_CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Load data extraction
  // --------------------------------------------------------------------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = r_data_mem[7:0];
    case (r_mem_addr)
      2'd0:    w_byte = r_data_mem[7:0];
      2'd1:    w_byte = r_data_mem[15:8];
      2'd2:    w_byte = r_data_mem[23:16];
      default: w_byte = r_data_mem[31:24];
    endcase
  end

  // Address bit 0 does not affect the selected half; an odd address is
  // reported as misaligned instead.
  assign w_half = r_mem_addr[1] ? r_data_mem[31:16] : r_data_mem[15:0];

  logic [XLEN-1:0] w_load_data;

  always_comb begin
    w_load_data = r_data_mem;
    case (r_funct3)
      c_F3_LB:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_F3_LBU: w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      c_F3_LH:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      c_F3_LHU: w_load_data = {{(XLEN-16){1'b0}}, w_half};
      c_F3_LW:  w_load_data = r_data_mem;
      default:  w_load_data = r_data_mem;
    endcase
  end

  // --------------------------------------------------------------------------
  // Misalignment: halves need an even address, words (and unknown funct3
  // values, which behave as words) need a zero address.
  // --------------------------------------------------------------------------
  logic w_is_load;
  logic w_addr_bad;
  logic w_misaligned;

  assign w_is_load = (r_opcode == c_OP_LOAD);

  always_comb begin
    w_addr_bad = 1'b0;
    case (r_funct3)
      c_F3_LB, c_F3_LBU: w_addr_bad = 1'b0;
      c_F3_LH, c_F3_LHU: w_addr_bad = r_mem_addr[0];
      default:           w_addr_bad = (r_mem_addr != 2'd0);
    endcase
  end

  assign w_misaligned = r_valid & w_is_load & w_addr_bad;

  // --------------------------------------------------------------------------
  // Write-back data select and write enable
  // --------------------------------------------------------------------------
  logic w_is_link;
  logic w_writes_rd;

  assign w_is_link = (r_opcode == c_OP_JAL) || (r_opcode == c_OP_JALR);

  always_comb begin
    w_writes_rd = 1'b0;
    case (r_opcode)
      c_OP_LOAD, c_OP_IMM, c_OP_REG, c_OP_JAL,
      c_OP_JALR, c_OP_LUI, c_OP_AUIPC: w_writes_rd = 1'b1;
      default:                         w_writes_rd = 1'b0;
    endcase
  end

  always_comb begin
    wbdata_o = r_data;
    if (w_is_load) begin
      wbdata_o = w_load_data;
    end else if (w_is_link) begin
      wbdata_o = r_pc_next;
    end
  end

  // x0 is hard-wired zero, so writes targeting it are suppressed here.
  assign wb_en        = r_valid & w_writes_rd & (r_wbaddr != '0) & ~w_misaligned;
  assign wbaddr_o     = r_wbaddr;
  assign valid_o      = r_valid;
  assign misaligned_o = w_misaligned;
  assign instret_o    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_pipe
// Purpose  : Self-checking bench for wb_pipe. A driver issues stimulus and
//            pushes the expected outputs of a behavioural model into a queue;
//            a monitor pops and compares one entry per cycle. A second DUT
//            with a 4-bit counter exercises counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid_i, stall_i, flush_i;
  logic [31:0] instr_i, data_mem_i, data_i, pc_next_i;
  logic [1:0]  mem_addr_i;
  logic [4:0]  wbaddr_i;

  logic [31:0] wbdata_o;
  logic [4:0]  wbaddr_o;
  logic        wb_en, valid_o, misaligned_o;
  logic [63:0] instret_o;

  logic [31:0] wbdata4;
  logic [4:0]  wbaddr4;
  logic        wb_en4, valid4, mis4;
  logic [3:0]  instret4;

  wb_pipe #(.XLEN(32), .RADDR_W(5), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i),
    .flush_i(flush_i), .instr_i(instr_i), .data_mem_i(data_mem_i),
    .data_i(data_i), .pc_next_i(pc_next_i), .mem_addr_i(mem_addr_i),
    .wbaddr_i(wbaddr_i), .wbdata_o(wbdata_o), .wbaddr_o(wbaddr_o),
    .wb_en(wb_en), .valid_o(valid_o), .misaligned_o(misaligned_o),
    .instret_o(instret_o)
  );

  wb_pipe #(.XLEN(32), .RADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i),
    .flush_i(flush_i), .instr_i(instr_i), .data_mem_i(data_mem_i),
    .data_i(data_i), .pc_next_i(pc_next_i), .mem_addr_i(mem_addr_i),
    .wbaddr_i(wbaddr_i), .wbdata_o(wbdata4), .wbaddr_o(wbaddr4),
    .wb_en(wb_en4), .valid_o(valid4), .misaligned_o(mis4),
    .instret_o(instret4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural reference model
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] wbdata;
    logic [4:0]  wbaddr;
    logic        wb_en;
    logic        valid;
    logic        mis;
    logic [63:0] cnt;
  } exp_t;

  exp_t q[$];

  bit          m_valid;
  bit [31:0]   m_instr, m_mem, m_data, m_pc;
  bit [1:0]    m_addr;
  bit [4:0]    m_rd;
  longint unsigned m_cnt;

  function automatic bit [31:0] ext_load(bit [2:0] f3, bit [31:0] mem, bit [1:0] a);
    bit [31:0] b, h;
    b = (mem >> (8 * a)) & 32'hFF;
    h = (mem >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return mem;
    endcase
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    bit [6:0] op;
    bit [2:0] f3;
    bit ld, half, byt, writes;
    op   = m_instr[6:0];
    f3   = m_instr[14:12];
    ld   = (op == 7'h03);
    byt  = (f3 == 0) || (f3 == 4);
    half = (f3 == 1) || (f3 == 5);
    e.mis = m_valid && ld && ((half && (m_addr % 2 == 1)) || (!byt && !half && m_addr != 0));
    if (ld)                                e.wbdata = ext_load(f3, m_mem, m_addr);
    else if (op == 7'h6F || op == 7'h67)   e.wbdata = m_pc;
    else                                   e.wbdata = m_data;
    writes = (op == 7'h03) || (op == 7'h13) || (op == 7'h33) || (op == 7'h6F) ||
             (op == 7'h67) || (op == 7'h37) || (op == 7'h17);
    e.wb_en  = m_valid && writes && (m_rd != 0) && !e.mis;
    e.wbaddr = m_rd;
    e.valid  = m_valid;
    e.cnt    = m_cnt;
    return e;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_instr = 0; m_mem = 0; m_data = 0; m_pc = 0;
    m_addr = 0; m_rd = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (flush_i) begin
      m_valid = 0;
    end else if (!stall_i) begin
      m_valid = valid_i; m_instr = instr_i; m_mem = data_mem_i;
      m_data = data_i; m_pc = pc_next_i; m_addr = mem_addr_i; m_rd = wbaddr_i;
      if (valid_i) m_cnt = m_cnt + 1;
    end
  endtask

  // One cycle of stimulus: applied at the falling edge, captured at the next rise.
  task automatic drive(input bit v, input bit s, input bit f, input bit [31:0] ins,
                       input bit [31:0] mem, input bit [31:0] dat, input bit [31:0] pc,
                       input bit [1:0] a, input bit [4:0] rd);
    @(negedge clk);
    valid_i = v; stall_i = s; flush_i = f; instr_i = ins; data_mem_i = mem;
    data_i = dat; pc_next_i = pc; mem_addr_i = a; wbaddr_i = rd;
    model_step();
    q.push_back(expect_now());
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wbdata"},  {32'd0, wbdata_o}, 64'd0);
    chk({tag, "_wbaddr"},  {59'd0, wbaddr_o}, 64'd0);
    chk({tag, "_wb_en"},   {63'd0, wb_en}, 64'd0);
    chk({tag, "_valid"},   {63'd0, valid_o}, 64'd0);
    chk({tag, "_mis"},     {63'd0, misaligned_o}, 64'd0);
    chk({tag, "_instret"}, instret_o, 64'd0);
    chk({tag, "_instret4"}, {60'd0, instret4}, 64'd0);
  endtask

  // Asynchronous reset pulse between clock edges, then an idle cycle.
  task automatic reset_pulse();
    @(negedge clk);
    valid_i = 0; stall_i = 0; flush_i = 0;
    #1 reset = 1;
    #1 check_all_zero("async_rst");
    #1 reset = 0;
    model_reset();
    model_step();
    q.push_back(expect_now());
  endtask

  function automatic bit [31:0] mk_instr(bit [6:0] op, bit [2:0] f3, bit [4:0] rd);
    bit [31:0] w;
    w = 32'h0;
    w[6:0] = op; w[11:7] = rd; w[14:12] = f3;
    return w;
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: one expected entry per clock after the capturing edge.
  // --------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mon_valid", {63'd0, valid_o}, {63'd0, e.valid});
        chk("mon_wb_en", {63'd0, wb_en}, {63'd0, e.wb_en});
        chk("mon_mis", {63'd0, misaligned_o}, {63'd0, e.mis});
        chk("mon_instret", instret_o, e.cnt);
        chk("mon_instret4", {60'd0, instret4}, {60'd0, e.cnt[3:0]});
        if (e.valid) begin
          chk("mon_wbdata", {32'd0, wbdata_o}, {32'd0, e.wbdata});
          chk("mon_wbaddr", {59'd0, wbaddr_o}, {59'd0, e.wbaddr});
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  initial begin : driver
    bit [6:0] ops [10];
    bit [31:0] ins;
    bit [63:0] base;
    int wait_cnt;
    ops = '{7'h03, 7'h03, 7'h13, 7'h33, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h23, 7'h63};

    reset = 1; valid_i = 0; stall_i = 0; flush_i = 0; instr_i = 0;
    data_mem_i = 0; data_i = 0; pc_next_i = 0; mem_addr_i = 0; wbaddr_i = 0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 0;
    model_reset();

    // LB sign-extends byte 2 (0xFF)
    drive(1, 0, 0, mk_instr(7'h03, 3'd0, 5'd5), 32'h80FF7F01, 32'h0, 32'h0, 2'd2, 5'd5);
    @(posedge clk); #2;
    chk("lb_wbdata", {32'd0, wbdata_o}, 64'hFFFFFFFF);
    chk("lb_wbaddr", {59'd0, wbaddr_o}, 64'd5);
    chk("lb_wb_en", {63'd0, wb_en}, 64'd1);
    chk("lb_instret", instret_o, 64'd1);

    // LHU upper half, then same at odd address
    drive(1, 0, 0, mk_instr(7'h03, 3'd5, 5'd6), 32'h80FF7F01, 32'h0, 32'h0, 2'd2, 5'd6);
    @(posedge clk); #2;
    chk("lhu_wbdata", {32'd0, wbdata_o}, 64'h000080FF);
    drive(1, 0, 0, mk_instr(7'h03, 3'd5, 5'd6), 32'h80FF7F01, 32'h0, 32'h0, 2'd1, 5'd6);
    @(posedge clk); #2;
    chk("lhu_mis", {63'd0, misaligned_o}, 64'd1);
    chk("lhu_mis_wb_en", {63'd0, wb_en}, 64'd0);
    chk("lhu_mis_instret", instret_o, 64'd3);

    // JAL link value, then JAL to x0
    drive(1, 0, 0, mk_instr(7'h6F, 3'd0, 5'd1), 32'h0, 32'hDEAD, 32'h104, 2'd0, 5'd1);
    @(posedge clk); #2;
    chk("jal_wbdata", {32'd0, wbdata_o}, 64'h104);
    chk("jal_wb_en", {63'd0, wb_en}, 64'd1);
    drive(1, 0, 0, mk_instr(7'h6F, 3'd0, 5'd0), 32'h0, 32'hDEAD, 32'h104, 2'd0, 5'd0);
    @(posedge clk); #2;
    chk("jal_x0_wb_en", {63'd0, wb_en}, 64'd0);
    chk("jal_x0_valid", {63'd0, valid_o}, 64'd1);

    // ADDI held through a 3-cycle stall while inputs change
    drive(1, 0, 0, mk_instr(7'h13, 3'd0, 5'd3), 32'h0, 32'd7, 32'h0, 2'd0, 5'd3);
    base = instret_o + 64'd1;
    for (int i = 0; i < 3; i++)
      drive(1, 1, 0, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 5'($urandom));
    @(posedge clk); #2;
    chk("stall_wbdata", {32'd0, wbdata_o}, 64'd7);
    chk("stall_wbaddr", {59'd0, wbaddr_o}, 64'd3);
    chk("stall_wb_en", {63'd0, wb_en}, 64'd1);
    chk("stall_instret", instret_o, base);

    // Flush beats stall; store retires without writing
    base = instret_o;
    drive(1, 1, 1, mk_instr(7'h13, 3'd0, 5'd9), 32'h0, 32'd1, 32'h0, 2'd0, 5'd9);
    @(posedge clk); #2;
    chk("flush_valid", {63'd0, valid_o}, 64'd0);
    chk("flush_wb_en", {63'd0, wb_en}, 64'd0);
    chk("flush_instret", instret_o, base);
    drive(1, 0, 0, mk_instr(7'h23, 3'd2, 5'd4), 32'h0, 32'd1, 32'h0, 2'd0, 5'd4);
    @(posedge clk); #2;
    chk("store_wb_en", {63'd0, wb_en}, 64'd0);
    chk("store_instret", instret_o, base + 64'd1);

    // Randomized traffic with an async reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_pulse();
      ins = $urandom;
      ins[6:0] = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
            ins, $urandom, $urandom, $urandom, 2'($urandom), 5'($urandom));
    end

    // 16 captures wrap the 4-bit counter back to zero
    reset_pulse();
    for (int i = 0; i < 16; i++)
      drive(1, 0, 0, mk_instr(7'h13, 3'd0, 5'd2), 32'h0, i, 32'h0, 2'd0, 5'd2);
    @(posedge clk); #2;
    chk("wrap_instret4", {60'd0, instret4}, 64'd0);
    chk("wrap_instret", instret_o, 64'd16);

    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 5'd0);
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_pipe.md
Name: wb_pipe

Overview:
Parametrised successor to the combinational write-back stage. It adds a registered MEM/WB pipeline boundary with valid/stall/flush control. It also adds load-data extraction (byte/half/word, signed/unsigned) with misalignment detection, x0 write suppression, and a retired-instruction counter. It sits between the memory stage and the register file, and its outputs drive the regfile write port and the forwarding network.

Parameters:
XLEN, 32, data/PC width in bits (32 only for load extraction semantics; LW returns full word)
RADDR_W, 5, register address width
CNT_W, 64, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
valid_i  input  1  MEM stage presents a valid instruction
stall_i  input  1  hold pipeline register contents
flush_i  input  1  discard incoming instruction (bubble)
instr_i  input  32  instruction word
data_mem_i  input  XLEN  raw aligned word read from data memory
data_i  input  XLEN  ALU result (covers LUI, AUIPC, I, R)
pc_next_i  input  XLEN  PC+4 link value
mem_addr_i  input  2  low bits of load address
wbaddr_i  input  RADDR_W  destination register
wbdata_o  output  XLEN  write-back data
wbaddr_o  output  RADDR_W  write-back register address
wb_en  output  1  regfile write enable
valid_o  output  1  registered entry valid
misaligned_o  output  1  registered entry is a misaligned load
instret_o  output  CNT_W  retired instruction count

Behaviour:
- Reset (async, active-high): all registered fields cleared, including valid_q and the counter. Outputs during and after reset: wbdata_o=0, wbaddr_o=0, wb_en=0, valid_o=0, misaligned_o=0, instret_o=0.
- Register update at rising clk, priority reset > flush > stall > capture:
  - flush_i=1: valid_q<=0; other fields don't-care. Flush wins over stall.
  - stall_i=1 (no flush): all fields hold.
  - otherwise: capture valid_i, instr, data_mem, data, pc_next, mem_addr, wbaddr.
- Latency: inputs captured at edge N appear on outputs after edge N (1 cycle). All outputs are combinational from registered fields only; no input-to-output path.
- opcode = instr_q[6:0]; funct3 = instr_q[14:12].
- Load extraction (opcode 0000011), selected byte/half chosen by mem_addr_q:
  - LB (000): sign-extend byte.
  - LBU (100): zero-extend byte.
  - LH (001): sign-extend half at addr[1]*16.
  - LHU (101): zero-extend half at addr[1]*16.
  - LW (010): full word.
  - Other funct3 values: treated as LW.
- misaligned = valid_q & load & (LH/LHU with addr[0]=1, or LW with addr≠0).
- wbdata_o:
  - load: extracted data.
  - JAL (1101111) or JALR (1100111): pc_next_q.
  - else: data_q.
- wb_en = valid_q & opcode ∈ {I 0010011, R 0110011, L, JAL, JALR, LUI 0110111, AUIPC 0010111} & wbaddr_q≠0 & ~misaligned.
- wbaddr_o = wbaddr_q; valid_o = valid_q; misaligned_o = misaligned.
- During stall the entry persists, so wb_en may stay high for several cycles (idempotent write). The counter does not re-count the held entry.
- instret counts captured instructions, including stores, branches and misaligned loads:
  - Increments at the edge where valid_i & ~stall_i & ~flush_i.
  - Visible on instret_o the cycle after that edge.
  - Wraps from 2^CNT_W−1 to 0.
- Reset asserted mid-stall or mid-flush clears everything immediately, independent of clk.

Test Plan:
- Reset then LB: instr opcode 0000011 funct3 000, rd=5, data_mem_i=0x80FF7F01, addr=2, valid_i=1 → next cycle wbdata_o=0xFFFFFFFF, wbaddr_o=5, wb_en=1, instret_o=1.
- LHU at addr=2, data_mem_i=0x80FF7F01 → wbdata_o=0x000080FF. Same instruction at addr=1 → misaligned_o=1, wb_en=0, instret_o still increments.
- JAL rd=1, pc_next_i=0x00000104, data_i=0xDEAD → wbdata_o=0x104, wb_en=1. Same JAL with rd=0 → wb_en=0, valid_o=1.
- Stall: capture ADDI rd=3 data_i=7, then stall_i=1 for 3 cycles while inputs change → outputs hold 7/3/wb_en=1; instret_o increments by 1 only.
- Flush with stall_i=1 and valid_i=1 → next cycle valid_o=0, wb_en=0, instret unchanged. Store opcode 0100011 → wb_en=0, instret +1.
- Counter wrap with CNT_W=4: 16 captured valids → instret_o returns to 0. Async reset pulse mid-cycle (no clk edge) → all outputs 0 immediately.
